// File: rtl/pfd_tdc_lock.sv
// Sampled phase-frequency detector with saturating phase-error counter and lock detector.
// Ports: SYS_clk/RESET/EN control; IN_clk, FB_clk sampled clocks; flagU/flagD, PERR/PERR_vld, LOCK outputs.
module pfd_tdc_lock #(
  parameter int ERR_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_CNT    = 16
) (
  input  logic             SYS_clk,
  input  logic             RESET,
  input  logic             EN,
  input  logic             IN_clk,
  input  logic             FB_clk,
  output logic             flagU,
  output logic             flagD,
  output logic [ERR_W-1:0] PERR,
  output logic             PERR_vld,
  output logic             LOCK
);

  localparam int CW = ERR_W - 1;
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0]    MAX  = {CW{1'b1}};
  localparam logic [ERR_W-1:0] TOL  = ERR_W'(LOCK_TOL);
  localparam logic [LW-1:0]    LCNT = LW'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DN
  } state_t;

  logic [SYNC_STAGES-1:0] ref_sync_q;
  logic [SYNC_STAGES-1:0] fb_sync_q;
  logic                   ref_hist_q;
  logic                   fb_hist_q;
  logic                   ref_e_q;
  logic                   fb_e_q;

  state_t                 st_q;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          cnt_inc;
  logic                   up_q;
  logic                   dn_q;
  logic [ERR_W-1:0]       perr_q;
  logic                   perr_vld_q;
  logic [ERR_W-1:0]       perr_abs;

  logic [LW-1:0]          lock_cnt_q;
  logic [LW-1:0]          lock_cnt_d;
  logic                   lock_q;
  logic                   lock_d;

  assign cnt_inc  = (cnt_q == MAX) ? MAX : cnt_q + CW'(1);
  assign perr_abs = perr_q[ERR_W-1] ? (~perr_q + ERR_W'(1)) : perr_q;

  // Lock counter advances on the strobe registered in the previous cycle.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    lock_d     = lock_q;
    if (perr_vld_q) begin
      if (perr_abs <= TOL) begin
        if (lock_cnt_q != LCNT) lock_cnt_d = lock_cnt_q + LW'(1);
      end else begin
        lock_cnt_d = '0;
      end
      lock_d = (lock_cnt_d == LCNT);
    end
  end

  always_ff @(posedge SYS_clk) begin
    if (RESET) begin
      ref_sync_q <= '0;
      fb_sync_q  <= '0;
      ref_hist_q <= 1'b0;
      fb_hist_q  <= 1'b0;
      ref_e_q    <= 1'b0;
      fb_e_q     <= 1'b0;
      st_q       <= IDLE;
      cnt_q      <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      perr_q     <= '0;
      perr_vld_q <= 1'b0;
      lock_cnt_q <= '0;
      lock_q     <= 1'b0;
    end else begin
      // Synchronisers run regardless of EN so re-enable sees no false edge.
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], IN_clk};
      fb_sync_q  <= {fb_sync_q[SYNC_STAGES-2:0], FB_clk};
      ref_hist_q <= ref_sync_q[SYNC_STAGES-1];
      fb_hist_q  <= fb_sync_q[SYNC_STAGES-1];
      ref_e_q    <= ~ref_hist_q & ref_sync_q[SYNC_STAGES-1];
      fb_e_q     <= ~fb_hist_q & fb_sync_q[SYNC_STAGES-1];
      perr_vld_q <= 1'b0;
      if (!EN) begin
        st_q       <= IDLE;
        cnt_q      <= '0;
        up_q       <= 1'b0;
        dn_q       <= 1'b0;
        lock_cnt_q <= '0;
        lock_q     <= 1'b0;
      end else begin
        lock_cnt_q <= lock_cnt_d;
        lock_q     <= lock_d;
        unique case (st_q)
          IDLE: begin
            if (ref_e_q && fb_e_q) begin
              perr_q     <= '0;
              perr_vld_q <= 1'b1;
            end else if (ref_e_q) begin
              st_q  <= UP;
              cnt_q <= CW'(1);
              up_q  <= 1'b1;
            end else if (fb_e_q) begin
              st_q  <= DN;
              cnt_q <= CW'(1);
              dn_q  <= 1'b1;
            end
          end
          UP: begin
            if (fb_e_q) begin
              perr_q     <= {1'b0, cnt_q};
              perr_vld_q <= 1'b1;
              if (ref_e_q) begin
                cnt_q <= CW'(1);
              end else begin
                st_q  <= IDLE;
                cnt_q <= '0;
                up_q  <= 1'b0;
              end
            end else if (ref_e_q) begin
              // Second reference edge before feedback: cycle slip.
              cnt_q <= MAX;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          DN: begin
            if (ref_e_q) begin
              perr_q     <= -{1'b0, cnt_q};
              perr_vld_q <= 1'b1;
              if (fb_e_q) begin
                cnt_q <= CW'(1);
              end else begin
                st_q  <= IDLE;
                cnt_q <= '0;
                dn_q  <= 1'b0;
              end
            end else if (fb_e_q) begin
              cnt_q <= MAX;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            st_q  <= IDLE;
            cnt_q <= '0;
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign flagU    = up_q;
  assign flagD    = dn_q;
  assign PERR     = perr_q;
  assign PERR_vld = perr_vld_q;
  assign LOCK     = lock_q;

endmodule
